// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, PC increment and default reset PC.
package fetch_pkg;

  localparam int unsigned          PC_STEP          = 4;
  localparam logic [31:0]          DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction-memory req/ack, instruction-register load and the decode handshake.
interface fetch_ctrl_if #(
  parameter int BITS = 32
);

  logic            mem_req;
  logic [BITS-1:0] mem_addr;
  logic            mem_ack;
  logic [BITS-1:0] mem_rdata;
  logic            ir_load;
  logic [BITS-1:0] ir_data;
  logic            inst_valid;
  logic [BITS-1:0] inst_pc;
  logic            advance;
  logic            stall;
  logic            redirect;
  logic [BITS-1:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, ir_load, ir_data, inst_valid, inst_pc,
    input  mem_ack, mem_rdata, advance, stall, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, ir_load, ir_data, inst_valid, inst_pc,
    output mem_ack, mem_rdata, advance, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches one word at a time, hands it to decode.
// ir_load is combinational in the ack cycle; inst_valid rises the cycle after.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = BITS'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  fetch_ctrl_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [BITS-1:0] pc_q, pc_d;
  logic            discard_q, discard_d;
  logic [BITS-1:0] drain_addr_q, drain_addr_d;
  logic [BITS-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = {bus.redirect_pc[BITS-1:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    drain_addr_d = drain_addr_q;

    case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          pc_d = redirect_pc_aligned;
        end else if (run) begin
          state_d = REQ;
        end
      end

      REQ: begin
        if (bus.redirect) begin
          pc_d = redirect_pc_aligned;
          // Without an ack the old request must stay on the bus until it completes.
          if (!bus.mem_ack) begin
            state_d      = DRAIN;
            discard_d    = 1'b1;
            drain_addr_d = pc_q;
          end
        end else if (bus.mem_ack) begin
          state_d = VALID;
        end
      end

      DRAIN: begin
        if (bus.redirect) begin
          pc_d = redirect_pc_aligned;
        end
        if (bus.mem_ack) begin
          state_d   = REQ;
          discard_d = 1'b0;
        end
      end

      VALID: begin
        if (bus.redirect) begin
          pc_d    = redirect_pc_aligned;
          state_d = REQ;
        end else if (bus.advance && !bus.stall) begin
          pc_d    = pc_q + BITS'(PC_STEP);
          state_d = REQ;
        end
      end

      default: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // Reset withdraws the request in the same cycle so the transaction is abandoned.
  assign bus.mem_req    = ((state_q == REQ) || (state_q == DRAIN)) && !reset;
  assign bus.mem_addr   = discard_q ? drain_addr_q : pc_q;
  assign bus.ir_load    = (state_q == REQ) && bus.mem_ack && !bus.redirect && !reset;
  assign bus.ir_data    = bus.mem_rdata;
  assign bus.inst_valid = (state_q == VALID);
  assign bus.inst_pc    = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scenarios plus randomized traffic, all checked against a transaction-level fetch model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;
  logic run;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.BITS(32)) bus ();

  fetch_ctrl #(.BITS(32), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .bus   (bus)
  );

  // Reference model: is fetching enabled, is a memory request in flight, is that request
  // stale (its data will be thrown away), is a word held for decode, and the PC.
  bit          m_running;
  bit          m_outstanding;
  bit          m_stale;
  bit          m_held;
  logic [31:0] m_pc;
  logic [31:0] m_stale_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sample();
    logic [31:0] exp_addr;
    @(negedge clk);
    exp_addr = m_stale ? m_stale_addr : m_pc;
    chk("m_req",   32'(bus.mem_req),    32'(m_outstanding && !reset));
    chk("m_addr",  bus.mem_addr,        exp_addr);
    chk("m_load",  32'(bus.ir_load),
        32'(!reset && m_outstanding && !m_stale && bus.mem_ack && !bus.redirect));
    chk("m_idata", bus.ir_data,         bus.mem_rdata);
    chk("m_valid", 32'(bus.inst_valid), 32'(m_held));
    chk("m_ipc",   bus.inst_pc,         m_pc);
  endtask

  task automatic step();
    logic [31:0] rp;
    @(posedge clk);
    rp = bus.redirect_pc & 32'hFFFF_FFFC;
    if (reset) begin
      m_running = 0; m_outstanding = 0; m_stale = 0; m_held = 0; m_pc = RST_PC; m_stale_addr = RST_PC;
    end else if (!m_running) begin
      if (bus.redirect) m_pc = rp;
      else if (run) begin m_running = 1; m_outstanding = 1; end
    end else if (m_outstanding) begin
      if (bus.mem_ack) begin
        if (m_stale) m_stale = 0;
        else if (!bus.redirect) begin m_outstanding = 0; m_held = 1; end
      end else if (bus.redirect && !m_stale) begin
        m_stale = 1;
        m_stale_addr = m_pc;
      end
      if (bus.redirect) m_pc = rp;
    end else if (m_held) begin
      if (bus.redirect) begin
        m_pc = rp; m_held = 0; m_outstanding = 1;
      end else if (bus.advance && !bus.stall) begin
        m_pc = m_pc + 32'd4; m_held = 0; m_outstanding = 1;
      end
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    step();
  endtask

  initial begin
    m_running = 0; m_outstanding = 0; m_stale = 0; m_held = 0; m_pc = RST_PC; m_stale_addr = RST_PC;
    reset = 1; run = 0;
    bus.mem_ack = 0; bus.mem_rdata = 32'h0; bus.advance = 0; bus.stall = 0;
    bus.redirect = 0; bus.redirect_pc = 32'h0;
    #1;
    cyc();
    sample();
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_valid", 32'(bus.inst_valid), 0);
    chk("rst_addr", bus.mem_addr, 32'h100);
    chk("rst_ipc", bus.inst_pc, 32'h100);
    step();

    // Zero-wait first fetch, then advance.
    reset = 0; run = 1;
    cyc();
    run = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h0050_0093;
    sample();
    chk("zw_addr", bus.mem_addr, 32'h100);
    chk("zw_load", 32'(bus.ir_load), 1);
    chk("zw_data", bus.ir_data, 32'h0050_0093);
    chk("zw_valid0", 32'(bus.inst_valid), 0);
    step();
    bus.mem_ack = 0; bus.advance = 1;
    sample();
    chk("zw_valid1", 32'(bus.inst_valid), 1);
    chk("zw_ipc", bus.inst_pc, 32'h100);
    chk("zw_load_off", 32'(bus.ir_load), 0);
    step();
    bus.advance = 0;

    // Three wait states at 0x104.
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("wait_req", 32'(bus.mem_req), 1);
      chk("wait_addr", bus.mem_addr, 32'h104);
      chk("wait_load", 32'(bus.ir_load), 0);
      step();
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
    sample();
    chk("wait_ack_load", 32'(bus.ir_load), 1);
    step();
    bus.mem_ack = 0;

    // Stall for five cycles while advance is high.
    bus.stall = 1; bus.advance = 1;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("stall_valid", 32'(bus.inst_valid), 1);
      chk("stall_req", 32'(bus.mem_req), 0);
      step();
    end
    bus.stall = 0;
    cyc();
    bus.advance = 0;
    sample();
    chk("stall_next_addr", bus.mem_addr, 32'h108);
    chk("stall_next_req", 32'(bus.mem_req), 1);
    step();

    // Redirect to 0x203 while the request at 0x108 is pending.
    bus.redirect = 1; bus.redirect_pc = 32'h203;
    sample();
    chk("drn_addr0", bus.mem_addr, 32'h108);
    chk("drn_load0", 32'(bus.ir_load), 0);
    step();
    bus.redirect = 0;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("drn_hold_req", 32'(bus.mem_req), 1);
      chk("drn_hold_addr", bus.mem_addr, 32'h108);
      step();
    end
    bus.mem_ack = 1;
    sample();
    chk("drn_ack_load", 32'(bus.ir_load), 0);
    step();
    bus.mem_ack = 0;
    sample();
    chk("drn_new_addr", bus.mem_addr, 32'h200);
    chk("drn_new_req", 32'(bus.mem_req), 1);
    step();

    // Redirect together with ack.
    bus.redirect = 1; bus.redirect_pc = 32'h300; bus.mem_ack = 1;
    sample();
    chk("ra_load", 32'(bus.ir_load), 0);
    step();
    bus.redirect = 0; bus.mem_ack = 0;
    sample();
    chk("ra_addr", bus.mem_addr, 32'h300);
    chk("ra_valid", 32'(bus.inst_valid), 0);
    step();
    bus.mem_ack = 1;
    cyc();
    bus.mem_ack = 0;

    // Redirect beats advance in VALID.
    bus.redirect = 1; bus.redirect_pc = 32'h400; bus.advance = 1;
    sample();
    chk("rv_valid", 32'(bus.inst_valid), 1);
    step();
    bus.redirect = 0; bus.advance = 0;
    sample();
    chk("rv_valid_drop", 32'(bus.inst_valid), 0);
    chk("rv_addr", bus.mem_addr, 32'h400);
    step();

    // PC wrap-around.
    bus.redirect = 1; bus.redirect_pc = 32'hFFFF_FFFC; bus.mem_ack = 1;
    cyc();
    bus.redirect = 0;
    sample();
    chk("wrap_top", bus.mem_addr, 32'hFFFF_FFFC);
    step();
    bus.mem_ack = 0; bus.advance = 1;
    cyc();
    bus.advance = 0;
    sample();
    chk("wrap_zero", bus.mem_addr, 32'h0);
    chk("wrap_req", 32'(bus.mem_req), 1);
    step();

    // Reset in the middle of a request.
    reset = 1;
    sample();
    chk("mid_rst_req", 32'(bus.mem_req), 0);
    step();
    reset = 0;
    sample();
    chk("post_rst_req", 32'(bus.mem_req), 0);
    chk("post_rst_addr", bus.mem_addr, 32'h100);
    step();

    // Redirect in IDLE keeps the block idle even with run high.
    bus.redirect = 1; bus.redirect_pc = 32'h55; run = 1;
    cyc();
    bus.redirect = 0; run = 0;
    sample();
    chk("idle_redir_req", 32'(bus.mem_req), 0);
    chk("idle_redir_ipc", bus.inst_pc, 32'h54);
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 299) == 0);
      run             = ($urandom_range(0, 3) == 0);
      bus.mem_ack     = ($urandom_range(0, 1) == 0);
      bus.mem_rdata   = $urandom;
      bus.advance     = ($urandom_range(0, 2) != 0);
      bus.stall       = ($urandom_range(0, 3) == 0);
      bus.redirect    = ($urandom_range(0, 7) == 0);
      bus.redirect_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
